// File: rtl/uart_rx_core.sv
// Purpose: oversampling UART receiver; start, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Latency: start edge seen in IDLE to data_valid = (1 + DATA_WIDTH + PAR_EN) * P + P/2 + 2 CLK cycles.
// Backpressure: none; data_valid/par_err/stop_err are one-cycle strobes the consumer must take when they fire.
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote at edge_cnt P/2-1, P/2, P/2+1.
module uart_rx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [5:0]            edge_cnt;
  logic [5:0]            p_lat;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  frame_perr;

  logic [5:0]            p_sel;
  logic [5:0]            p_half;
  logic                  is_dec;
  logic                  is_last;
  logic                  bit_val;
  logic                  exp_par;

  // Map the requested oversampling ratio onto the three supported values; anything else runs at 8.
  always_comb begin
    p_sel = 6'd8;
    if (Prescale == 6'd16 || Prescale == 6'd32) begin
      p_sel = Prescale;
    end
  end

  assign p_half  = {1'b0, p_lat[5:1]};
  assign is_dec  = (edge_cnt == p_half + 6'd1);
  assign is_last = (edge_cnt == p_lat - 6'd1);

  // Parity bit the sender should have placed after the data bits just shifted in.
  assign exp_par = (^shreg) ^ PAR_TYP;

`ifdef UART_RX_MAJORITY_EN
  logic samp_a;
  logic samp_b;

  // Capture the two early votes of the current bit; the third vote is the live line at the decision edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (state != IDLE) begin
      if (edge_cnt == p_half - 6'd1) begin
        samp_a <= RX_IN;
      end
      if (edge_cnt == p_half) begin
        samp_b <= RX_IN;
      end
    end
  end

  assign bit_val = (samp_a & samp_b) | (samp_a & RX_IN) | (samp_b & RX_IN);
`else
  assign bit_val = RX_IN;
`endif

  // Frame FSM with its counters and registered output strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_lat      <= 6'd8;
      shreg      <= '0;
      frame_perr <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          bit_cnt  <= '0;
          if (!RX_IN) begin
            state      <= START;
            p_lat      <= p_sel;
            frame_perr <= 1'b0;
          end
        end

        START: begin
          if (is_dec && bit_val) begin
            // Line went back high before mid-bit: treat as noise.
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (is_last) begin
            state    <= DATA;
            edge_cnt <= '0;
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end

        DATA: begin
          if (is_dec) begin
            shreg <= (shreg >> 1) | (DATA_WIDTH'(bit_val) << (DATA_WIDTH - 1));
          end
          if (is_last) begin
            edge_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= PAR_EN ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end

        PARITY: begin
          if (is_dec && (bit_val != exp_par)) begin
            par_err    <= 1'b1;
            frame_perr <= 1'b1;
          end
          if (is_last) begin
            state    <= STOP;
            edge_cnt <= '0;
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end

        STOP: begin
          if (is_dec) begin
            if (!bit_val) begin
              stop_err <= 1'b1;
            end else if (!frame_perr) begin
              P_DATA     <= shreg;
              data_valid <= 1'b1;
            end
            // Leave now so a start bit immediately following the stop bit is caught.
            state    <= IDLE;
            edge_cnt <= '0;
          end else begin
            edge_cnt <= edge_cnt + 6'd1;
          end
        end

        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial-to-parallel UART receiver for the system's UART link: the receive-side counterpart of the UART transmitter's idle/start/data/parity framing. It oversamples `RX_IN` at a programmable prescale and recovers one frame: start bit, `DATA_WIDTH` data bits LSB-first, an optional parity bit and one stop bit. It delivers the byte to the system controller with a one-cycle valid strobe and flags parity and stop-bit errors.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `CLK`  in  1  RX clock, running at baud rate × `Prescale`.
- `RST`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line; idle high. Already synchronised upstream.
- `PAR_EN`  in  1  1 = frame carries a parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `Prescale`  in  6  oversampling ratio.
  - Legal values: 8, 16, 32. Any other value is treated as 8.
- `P_DATA`  out  `DATA_WIDTH`  last correctly received byte.
- `data_valid`  out  1  one-cycle strobe; `P_DATA` is new.
- `par_err`  out  1  one-cycle strobe; parity mismatch.
- `stop_err`  out  1  one-cycle strobe; stop bit sampled 0.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Counters:**
  - `edge_cnt` runs 0..P-1 within each bit. P is `Prescale`, latched on IDLE→START.
  - `bit_cnt` runs 0..`DATA_WIDTH`-1 in DATA.
- **Bit decision:** taken at `edge_cnt` = P/2+1 (the decision edge).
- **IDLE:**
  - All counters are 0.
  - `RX_IN`=0 moves to START next cycle, with `edge_cnt`=0 in the first START cycle.
- **START:**
  - If the sampled value is 1 (glitch), return to IDLE at the decision edge.
  - Otherwise go to DATA at `edge_cnt`=P-1.
- **DATA:**
  - Sampled bit shifts into the shift register MSB, with a right shift (LSB-first line order).
  - After bit `DATA_WIDTH`-1 completes, go to PARITY if `PAR_EN`=1, else STOP.
- **PARITY:**
  - Expected bit = XOR of data bits XOR `PAR_TYP`.
  - On mismatch, pulse `par_err` at the decision edge and record the error for the frame.
  - Go to STOP at `edge_cnt`=P-1.
- **STOP:**
  - At the decision edge, a sampled 0 pulses `stop_err`.
  - In the same cycle, if there is no stop or parity error: `P_DATA` ← shift register and `data_valid`=1.
  - The FSM then returns to IDLE immediately, without waiting for the rest of the stop bit, so a back-to-back start edge is caught.
- **On error:** `P_DATA` keeps its previous value and `data_valid` stays 0.
- **Input stability:** `PAR_EN` and `PAR_TYP` are sampled at the cycle they are used. Software changes them only while the link is idle.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - `P_DATA`=0, `data_valid`=0, `par_err`=0, `stop_err`=0.
  - Counters = 0.
- **Reset mid-frame:** frame is discarded; no strobes follow reset release.
- **All outputs are registered.**
- **Strobe length:** exactly 1 `CLK` cycle each.
- **Error timing:** `par_err` and `stop_err` never coincide within one frame's cycle. `stop_err` may follow `par_err` in the same frame.
- **Latency:** falling start edge seen in IDLE → `data_valid` high is
  - (1 + `DATA_WIDTH` + `PAR_EN`) × P + P/2 + 2 cycles.
  - Example: P=8, 8N1 → 78 cycles.
- **Back-to-back frames:**
  - Each frame's stop bit is 1 bit-time long. The FSM leaves STOP at the decision edge (P/2+1), so it is back in IDLE for the remainder of the stop bit, roughly P/2-2 cycles.
  - It catches the next start edge on the first 0 seen in IDLE.
  - No gap between frames is required.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Bit value = majority of three samples, taken at `edge_cnt` P/2-1, P/2 and P/2+1.
  - Decision at P/2+1.
- Not defined:
  - Single sample at `edge_cnt` P/2+1.
  - Decision edge, strobe timing and latency are identical in both builds.

## Test plan
- P=8, `PAR_EN`=0, frame 0xA5 → `P_DATA`=0xA5, `data_valid` pulse 78 cycles after the start edge; no error strobes.
- P=16, `PAR_EN`=1, `PAR_TYP`=0, 0x3C with parity 0 → `P_DATA`=0x3C, `data_valid`=1, `par_err`=0.
  - Same byte with parity 1 → `par_err` pulse; `P_DATA` stays 0x3C from before; no `data_valid`.
- P=32, 0x81 with stop bit 0 → `stop_err` pulse; no `data_valid`; next good frame 0x42 → `P_DATA`=0x42.
- Start glitch: `RX_IN` low for 2 cycles at P=8 → FSM returns to IDLE; no strobes; a following 0x55 frame is received correctly.
  - With `UART_RX_MAJORITY_EN`: a 1-cycle inverted spike at P/2 on data bit 3 of 0xF0 → 0xF0 still received.
- Back-to-back 0x11 then 0xEE with no idle gap → two `data_valid` pulses exactly 10×P cycles apart.
  - Assert `RST` mid-data → outputs 0 immediately; no strobe after release until the next complete frame.
